// File: rtl/cache_arbiter.sv
// -----------------------------------------------------------------------------
// cache_arbiter
//
// Front end for the shared data cache. Each of NUM_CPU processor ports feeds
// its own request FIFO. A round-robin arbiter pops one FIFO head per cycle
// into a single output register that drives the cache request line. Cache
// responses are registered and steered back to the issuing port by the id
// field of the response word.
//
// Word packing (MSB first): {id, ls, tag, offset, data}
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous, active-low reset
//   req_valid        per-port request strobe
//   req_bus          per-port request words, port i at [i*REQ_W +: REQ_W]
//   req_ready        per-port "FIFO not full"
//   cache_req        registered request presented to the cache
//   cache_req_valid  cache_req holds a valid request
//   cache_busy       cache cannot accept the presented request this cycle
//   cache_rsp        response word from the cache
//   cache_rsp_valid  cache_rsp valid this cycle
//   rsp_valid        registered one-hot response strobe to the owning port
//   rsp_data         registered response word, broadcast to all ports
//   bad_id           sticky: a response arrived with id >= NUM_CPU
// -----------------------------------------------------------------------------
module cache_arbiter #(
  parameter  int NUM_CPU    = 2,
  parameter  int TAG_W      = 11,
  parameter  int OFF_W      = 1,
  parameter  int DATA_W     = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int ID_W       = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1,
  localparam int REQ_W      = ID_W + 1 + TAG_W + OFF_W + DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CPU-1:0]       req_valid,
  input  logic [NUM_CPU*REQ_W-1:0] req_bus,
  output logic [NUM_CPU-1:0]       req_ready,
  output logic [REQ_W-1:0]         cache_req,
  output logic                     cache_req_valid,
  input  logic                     cache_busy,
  input  logic [REQ_W-1:0]         cache_rsp,
  input  logic                     cache_rsp_valid,
  output logic [NUM_CPU-1:0]       rsp_valid,
  output logic [REQ_W-1:0]         rsp_data,
  output logic                     bad_id
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Everything below the id field; the id itself is replaced by the port index.
  localparam int PAY_W = REQ_W - ID_W;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [REQ_W-1:0] mem_q    [NUM_CPU][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [NUM_CPU];
  logic [PTR_W-1:0] wr_ptr_d [NUM_CPU];
  logic [PTR_W-1:0] rd_ptr_q [NUM_CPU];
  logic [PTR_W-1:0] rd_ptr_d [NUM_CPU];
  logic [CNT_W-1:0] cnt_q    [NUM_CPU];
  logic [CNT_W-1:0] cnt_d    [NUM_CPU];

  logic [ID_W-1:0]    rr_q, rr_d;
  logic [REQ_W-1:0]   cache_req_q, cache_req_d;
  logic               cache_req_valid_q, cache_req_valid_d;
  logic [NUM_CPU-1:0] rsp_valid_q, rsp_valid_d;
  logic [REQ_W-1:0]   rsp_data_q, rsp_data_d;
  logic               bad_id_q, bad_id_d;

  // ---------------------------------------------------------------------------
  // Push side
  // ---------------------------------------------------------------------------
  logic [NUM_CPU-1:0]      push;
  logic [NUM_CPU-1:0]      pop;
  logic [NUM_CPU-1:0]      not_empty;
  logic [REQ_W-1:0]        push_word [NUM_CPU];
  // Incoming id bits are deliberately discarded so ports cannot spoof ids.
  logic [NUM_CPU*ID_W-1:0] unused_req_id;

  // NOTE: every signal driven in always_comb gets a default at the top of the
  // block so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    unused_req_id = '0;
    for (int i = 0; i < NUM_CPU; i++) begin
      // Ready depends only on the registered count, so a full FIFO never
      // accepts a push in the cycle it pops.
      req_ready[i]  = (cnt_q[i] != CNT_W'(FIFO_DEPTH));
      not_empty[i]  = (cnt_q[i] != '0);
      push[i]       = req_valid[i] && req_ready[i];
      push_word[i]  = {ID_W'(i), req_bus[i*REQ_W +: PAY_W]};
      unused_req_id[i*ID_W +: ID_W] = req_bus[i*REQ_W + PAY_W +: ID_W];
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbitration and output register
  // ---------------------------------------------------------------------------
  logic            out_free;
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic            load;
  logic [REQ_W-1:0] head_word;

  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    // Search starts at rr and wraps modulo NUM_CPU; first non-empty port wins.
    for (int k = 0; k < NUM_CPU; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_CPU) idx = idx - NUM_CPU;
      if (!grant_found && not_empty[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    head_word = '0;
    for (int i = 0; i < NUM_CPU; i++) begin
      if (grant_idx == ID_W'(i)) head_word = mem_q[i][rd_ptr_q[i]];
    end
  end

  always_comb begin
    // The output register is free when empty or being taken by the cache.
    out_free          = !cache_req_valid_q || !cache_busy;
    load              = out_free && grant_found;
    cache_req_d       = cache_req_q;
    cache_req_valid_d = cache_req_valid_q;
    rr_d              = rr_q;

    if (out_free) begin
      cache_req_valid_d = grant_found;
      if (grant_found) cache_req_d = head_word;
    end

    if (load) begin
      rr_d = (grant_idx == ID_W'(NUM_CPU - 1)) ? '0 : grant_idx + 1'b1;
    end

    for (int i = 0; i < NUM_CPU; i++) begin
      pop[i] = load && (grant_idx == ID_W'(i));
    end
  end

  // Pointers are power-of-two wide, so they wrap without explicit compare.
  always_comb begin
    for (int i = 0; i < NUM_CPU; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
      cnt_d[i]    = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Response routing
  // ---------------------------------------------------------------------------
  logic [ID_W-1:0] rsp_id;

  always_comb begin
    rsp_id      = cache_rsp[REQ_W-1 -: ID_W];
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    bad_id_d    = bad_id_q;
    if (cache_rsp_valid) begin
      rsp_data_d = cache_rsp;
      for (int i = 0; i < NUM_CPU; i++) begin
        if (rsp_id == ID_W'(i)) rsp_valid_d[i] = 1'b1;
      end
      // No port matched: id is out of range for this configuration.
      if (rsp_valid_d == '0) bad_id_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CPU; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_q              <= '0;
      cache_req_q       <= '0;
      cache_req_valid_q <= 1'b0;
      rsp_valid_q       <= '0;
      rsp_data_q        <= '0;
      bad_id_q          <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CPU; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      rr_q              <= rr_d;
      cache_req_q       <= cache_req_d;
      cache_req_valid_q <= cache_req_valid_d;
      rsp_valid_q       <= rsp_valid_d;
      rsp_data_q        <= rsp_data_d;
      bad_id_q          <= bad_id_d;
    end
  end

  // NOTE: FIFO storage has no reset; the counts and pointers define which
  // entries are live, so stale contents after reset are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CPU; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= push_word[i];
    end
  end

  assign cache_req       = cache_req_q;
  assign cache_req_valid = cache_req_valid_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign bad_id          = bad_id_q;

endmodule
